// File: rtl/axi_burst_write_master.sv
// AXI write master: splits a job of total_words words into INCR bursts of up to BURST_LEN beats.
// Optional macro AXI_WM_ERR_ABORT_EN: an error response (bresp[1]) ends the job after that burst.
module axi_burst_write_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] total_words,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [7:0]            awlen,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  wvalid,
   input  logic                  wready,
   output logic                  wlast,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] addr_q, remaining_q;
   logic [7:0]            len_q, beat_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] beats_w, rem_after;
   logic                  resp_unused;

   // Beats of the next burst minus one: min(BURST_LEN, rem) - 1, rem assumed non-zero.
   function automatic logic [7:0] burst_len_m1(input logic [ADDR_WIDTH-1:0] rem);
      if (rem >= ADDR_WIDTH'(BURST_LEN))
         burst_len_m1 = 8'(BURST_LEN - 1);
      else
         burst_len_m1 = 8'(rem - ADDR_WIDTH'(1));
   endfunction

   assign beats_w     = ADDR_WIDTH'({1'b0, len_q}) + ADDR_WIDTH'(1);
   assign rem_after   = remaining_q - beats_w;
   assign resp_unused = bresp[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = (total_words != '0) ? ADDR : FIN;
         ADDR: if (awready) state_next = DATA;
         DATA: if (s_valid && wready && (beat_q == len_q)) state_next = RESP;
         RESP: begin
            if (bvalid) begin
`ifdef AXI_WM_ERR_ABORT_EN
               if (bresp[1])
                  state_next = FIN;
               else
`endif
               if (rem_after != '0)
                  state_next = ADDR;
               else
                  state_next = FIN;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Job bookkeeping; awaddr/awlen come straight from these registers so they hold during ADDR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  remaining_q <= total_words;
                  err_q       <= 1'b0;
                  len_q       <= (total_words != '0) ? burst_len_m1(total_words) : 8'd0;
               end
            end
            ADDR: if (awready) beat_q <= 8'd0;
            DATA: if (s_valid && wready) beat_q <= beat_q + 8'd1;
            RESP: begin
               if (bvalid) begin
                  if (bresp[1]) err_q <= 1'b1;
                  remaining_q <= rem_after;
                  addr_q      <= addr_q + beats_w;
                  if (rem_after != '0) len_q <= burst_len_m1(rem_after);
               end
            end
            default: ;
         endcase
      end
   end

   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awvalid = (state == ADDR);
   assign wdata   = s_data;
   assign wvalid  = (state == DATA) && s_valid;
   assign s_ready = (state == DATA) && wready;
   assign wlast   = (state == DATA) && (beat_q == len_q);
   assign bready  = (state == RESP);
   assign done    = (state == FIN);
   assign busy    = (state == ADDR) || (state == DATA) || (state == RESP);
   assign err     = err_q;

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Randomized bench for axi_burst_write_master: slave + stream model, burst plan and memory image
// computed from job arithmetic.
module tb_axi_burst_write_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BL = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr, total_words;
   logic [DW-1:0] s_data;
   logic          s_valid, s_ready;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic          awvalid, awready;
   logic [DW-1:0] wdata;
   logic          wvalid, wready, wlast;
   logic [1:0]    bresp;
   logic          bvalid, bready, busy, done, err;

   int vectorCount = 0;
   int miscompareCount = 0;

   bit randomReady;
   int stallBeat;
   int errBurst;
   bit exokay;
   logic [DW-1:0] mem [logic [AW-1:0]];

   always #5 clk = ~clk;

   axi_burst_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .total_words(total_words),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .busy(busy), .done(done), .err(err)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_aw"}, {awaddr, awlen, awvalid}, 64'd0);
      checkOutput({tag, "_ctl"}, {wvalid, wlast, bready, s_ready, busy, done, err}, 64'd0);
   endtask

   // Runs one job with the bench acting as stream source and AXI slave.
   task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] total);
      logic [DW-1:0] words[$];
      logic [AW-1:0] expAddr[$];
      logic [7:0]    expLen[$];
      logic [AW-1:0] off, beats, a, curAddr, prevAwaddr;
      logic [7:0]    prevAwlen;
      int  expWords, awIdx, wordIdx, srcIdx, beatInBurst, bPending, respIdx, stallLeft;
      bit  expErr, doneSeen, srcHold, awPendPrev, stallDone;

      for (int i = 0; i < int'(total); i++) words.push_back($urandom);
      off = '0;
      while (off < total) begin
         beats = (total - off > BL) ? AW'(BL) : total - off;
         expAddr.push_back(base + off);
         expLen.push_back(8'(beats - 1));
         off += beats;
      end
      expErr = (errBurst >= 0) && (errBurst < expAddr.size());
`ifdef AXI_WM_ERR_ABORT_EN
      if (expErr) while (expAddr.size() > errBurst + 1) begin
         void'(expAddr.pop_back());
         void'(expLen.pop_back());
      end
`endif
      expWords = 0;
      foreach (expLen[k]) expWords += int'(expLen[k]) + 1;
      mem.delete();

      awIdx = 0; wordIdx = 0; srcIdx = 0; beatInBurst = 0; bPending = 0; respIdx = 0;
      stallLeft = 0; stallDone = 0; doneSeen = 0; srcHold = 0; awPendPrev = 0;
      curAddr = '0; prevAwaddr = '0; prevAwlen = '0;

      @(negedge clk);
      start = 1'b1; base_addr = base; total_words = total;
      @(posedge clk);
      for (int cycle = 0; cycle < 3000; cycle++) begin
         @(negedge clk);
         start = 1'b0;
         base_addr = $urandom; total_words = $urandom;
         awready = randomReady ? ($urandom % 3 != 0) : 1'b1;
         if (!stallDone && stallBeat >= 0 && wordIdx == stallBeat) begin
            stallLeft = 3; stallDone = 1;
         end
         if (stallLeft > 0) begin
            wready = 1'b0; stallLeft--;
         end else wready = randomReady ? ($urandom % 4 != 0) : 1'b1;
         if (!srcHold) s_valid = (srcIdx < int'(total)) && (randomReady ? ($urandom % 3 != 0) : 1'b1);
         s_data = (srcIdx < int'(total)) ? words[srcIdx] : $urandom;
         bvalid = (bPending > 0) && (randomReady ? ($urandom % 2 == 1) : 1'b1);
         bresp  = (respIdx == errBurst) ? 2'b10 : (exokay ? 2'b01 : 2'b00);
         #1;
         if (cycle == 0 && total != 0) checkOutput("aw_after_start", {awvalid, busy}, 2'b11);
         if (awPendPrev) checkOutput("aw_hold", {awvalid, awaddr, awlen}, {1'b1, prevAwaddr, prevAwlen});
         if (awvalid || wvalid) checkOutput("aw_w_overlap", awvalid && wvalid, 1'b0);
         if (awvalid && awready) begin
            if (awIdx < expAddr.size()) begin
               checkOutput("awaddr", awaddr, expAddr[awIdx]);
               checkOutput("awlen", awlen, expLen[awIdx]);
               curAddr = expAddr[awIdx];
            end else checkOutput("aw_extra", awIdx, expAddr.size());
            awIdx++; beatInBurst = 0;
         end
         checkOutput("stream_hs", s_valid && s_ready, wvalid && wready);
         if (wvalid && wready) begin
            if (wordIdx < int'(total)) checkOutput("wdata", wdata, words[wordIdx]);
            if (awIdx > 0 && awIdx <= expLen.size())
               checkOutput("wlast", wlast, beatInBurst == int'(expLen[awIdx-1]));
            a = curAddr + AW'(beatInBurst);
            mem[a] = wdata;
            if (wlast) bPending++;
            beatInBurst++; wordIdx++;
         end
         srcHold = s_valid && !s_ready;
         if (s_valid && s_ready) srcIdx++;
         if (bvalid && bready) begin
            bPending--; respIdx++;
         end
         awPendPrev = awvalid && !awready;
         prevAwaddr = awaddr; prevAwlen = awlen;
         if (done) begin
            checkOutput("busy_at_done", busy, 1'b0);
            doneSeen = 1;
            break;
         end else if (total != 0) checkOutput("busy_in_job", busy, 1'b1);
      end
      checkOutput("done_seen", doneSeen, 1'b1);
      checkOutput("aw_count", awIdx, expAddr.size());
      checkOutput("b_count", respIdx, expAddr.size());
      checkOutput("word_count", wordIdx, expWords);
      checkOutput("err", err, expErr);
      for (int i = 0; i < expWords; i++) begin
         a = base + AW'(i);
         checkOutput("mem", mem.exists(a) ? mem[a] : 'x, words[i]);
      end
      s_valid = 1'b0; bvalid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("done_pulse", {done, busy}, 2'b00);
      checkOutput("err_sticky", err, expErr);
   endtask

   // Asynchronous reset while the fifth beat of a burst is being presented.
   task automatic resetMidBurst();
      int beatsDone = 0;
      bit hit = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 32'h100; total_words = 32'd16;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; s_valid = 1'b0;
      @(posedge clk);
      for (int cycle = 0; cycle < 100; cycle++) begin
         @(negedge clk);
         start = 1'b0; s_valid = 1'b1; s_data = $urandom;
         #1;
         if (wvalid && wready && beatsDone == 4) begin
            rst_n = 1'b0;
            #1;
            checkIdleOutputs("reset_mid");
            hit = 1;
            break;
         end
         if (wvalid && wready) beatsDone++;
      end
      checkOutput("reset_reached_beat5", hit, 1'b1);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; base_addr = '0; total_words = '0;
      s_data = '0; s_valid = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkIdleOutputs("reset");
      rst_n = 1'b1;

      randomReady = 0; stallBeat = -1; errBurst = -1; exokay = 0;
      applyStimulus(32'h10, 32'd16);
      applyStimulus(32'h10, 32'd37);
      randomReady = 1; stallBeat = 8;
      applyStimulus(32'h40, 32'd16);
      randomReady = 0; stallBeat = -1;
      applyStimulus(32'h20, 32'd0);
      errBurst = 1;
      applyStimulus(32'h10, 32'd37);
      errBurst = -1; exokay = 1;
      applyStimulus(32'h200, 32'd20);
      exokay = 0;
      resetMidBurst();
      applyStimulus(32'h300, 32'd18);
      randomReady = 1;
      applyStimulus(32'hFFFF_FFF8, 32'd20);
      for (int j = 0; j < 6; j++) begin
         stallBeat = int'($urandom_range(0, 20));
         errBurst  = ($urandom % 2) ? int'($urandom_range(0, 3)) : -1;
         exokay    = $urandom % 2;
         applyStimulus($urandom, (j == 2) ? 32'd0 : AW'($urandom_range(1, 60)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
